// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: state encodings, reset PC default and bench NOP.
// FAULT state exists only when FETCH_MISALIGN_CHECK_EN is defined.
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_e;
`endif

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_out_reg.sv
// Fetch output register: holds if_inst/if_pc and the hold-valid flag toward decode.
module fetch_out_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic        take_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o
);

    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;

    // Clear outranks load; a completed transfer only drops the valid flag.
    always_comb begin
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            inst_d  = inst_i;
            pc_d    = pc_i;
        end else if (take_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= RESET_PC;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// RISC-V fetch stage: single outstanding imem fetch, redirect with kill of wrong-path data.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_misalign
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         kill_q, kill_d;
    logic         out_load, out_clear;
    logic         hold_valid;
    logic         xfer;
    logic [31:0]  redir_target;
    logic         redir_bad;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_target   = redirect_pc;
    assign redir_bad      = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign fetch_misalign = (state_q == S_FAULT);
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redir_target   = word_align(redirect_pc);
    assign redir_bad      = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    assign imem_req  = reset_n && (state_q == S_REQ);
    assign imem_addr = pc_q;
    // A redirect in the same cycle suppresses the handoff of the held instruction.
    assign if_valid  = hold_valid && !redirect_valid;
    assign xfer      = if_valid && if_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        out_load  = 1'b0;
        out_clear = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (state_q == S_FAULT) begin
            out_clear = 1'b1;
        end else if (redir_bad) begin
            state_d   = S_FAULT;
            kill_d    = 1'b0;
            out_clear = 1'b1;
        end else
`endif
        begin
            case (state_q)
                S_REQ: begin
                    if (redirect_valid) begin
                        pc_d = redir_target;
                    end
                    if (imem_ready) begin
                        // Old address was accepted; its response is wrong-path if redirected.
                        kill_d  = redirect_valid;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        pc_d = redir_target;
                        if (imem_rvalid) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            kill_d = 1'b1;
                        end
                    end else if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else begin
                            out_load = 1'b1;
                            state_d  = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_valid) begin
                        out_clear = 1'b1;
                        pc_d      = redir_target;
                        state_d   = S_REQ;
                    end else if (xfer) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    fetch_out_reg #(
        .RESET_PC (RESET_PC)
    ) u_out_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (out_load),
        .clear_i (out_clear),
        .take_i  (xfer),
        .inst_i  (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (hold_valid),
        .inst_o  (if_inst),
        .pc_o    (if_pc)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; checks handshake timing, redirects/kill and PC wrap.
// Covers the FETCH_MISALIGN_CHECK_EN build when that macro is defined for both files.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_misalign;

    int unsigned n_cmp;
    int unsigned n_bad;

    instruction_fetch #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp          = 0;
        n_bad          = 0;
        reset_n        = 1'b0;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        repeat (2) tick();
        chk("rst_req",      {31'b0, imem_req}, 32'd0);
        chk("rst_addr",     imem_addr, 32'h0);
        chk("rst_valid",    {31'b0, if_valid}, 32'd0);
        chk("rst_inst",     if_inst, 32'h0);
        chk("rst_pc",       if_pc, 32'h0);
        chk("rst_misalign", {31'b0, fetch_misalign}, 32'd0);

        // First fetch, zero-wait memory
        reset_n = 1'b1;
        #1;
        chk("first_req",  {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        #1;
        chk("wait_req",   {31'b0, imem_req}, 32'd0);
        chk("wait_valid", {31'b0, if_valid}, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #1;
        chk("hold_valid", {31'b0, if_valid}, 32'd1);
        chk("hold_inst",  if_inst, 32'h0050_0093);
        chk("hold_pc",    if_pc, 32'h0);

        // Decode stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", {31'b0, if_valid}, 32'd1);
            chk("stall_inst",  if_inst, 32'h0050_0093);
            chk("stall_pc",    if_pc, 32'h0);
            chk("stall_req",   {31'b0, imem_req}, 32'd0);
        end
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        #1;
        chk("next_req",   {31'b0, imem_req}, 32'd1);
        chk("next_addr",  imem_addr, 32'h4);
        chk("next_valid", {31'b0, if_valid}, 32'd0);

        // Redirect to 0x100 while waiting; response 3 cycles later is dropped
        imem_ready = 1'b1;
        tick();
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        chk("kill_req", {31'b0, imem_req}, 32'd0);
        tick();
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("kill_valid0", {31'b0, if_valid}, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #1;
        chk("kill_valid1", {31'b0, if_valid}, 32'd0);
        chk("kill_req1",   {31'b0, imem_req}, 32'd1);
        chk("kill_addr",   imem_addr, 32'h100);

        // Fetch at 0x100, then redirect to 0x40 while holding with if_ready high
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = NOP_INST;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #1;
        chk("h100_valid", {31'b0, if_valid}, 32'd1);
        chk("h100_inst",  if_inst, 32'h0000_0013);
        chk("h100_pc",    if_pc, 32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        if_ready       = 1'b1;
        #1;
        chk("hredir_valid", {31'b0, if_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        #1;
        chk("hredir_req",   {31'b0, imem_req}, 32'd1);
        chk("hredir_addr",  imem_addr, 32'h40);
        chk("hredir_valid1", {31'b0, if_valid}, 32'd0);

        // Misaligned redirect to 0x102 from REQ without ready
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            chk("fault_flag",  {31'b0, fetch_misalign}, 32'd1);
            chk("fault_req",   {31'b0, imem_req}, 32'd0);
            chk("fault_valid", {31'b0, if_valid}, 32'd0);
            tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("fault_clr", {31'b0, fetch_misalign}, 32'd0);
        chk("fault_addr", imem_addr, 32'h0);
`else
        chk("align_req",      {31'b0, imem_req}, 32'd1);
        chk("align_addr",     imem_addr, 32'h100);
        chk("align_misalign", {31'b0, fetch_misalign}, 32'd0);
`endif

        // Redirect accepted together with imem_ready: old response killed
        imem_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        imem_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h1234_5678;
        #1;
        chk("rkill_req", {31'b0, imem_req}, 32'd0);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #1;
        chk("rkill_valid", {31'b0, if_valid}, 32'd0);
        chk("rkill_req1",  {31'b0, imem_req}, 32'd1);
        chk("rkill_addr",  imem_addr, 32'hFFFF_FFFC);

        // Fetch at 0xFFFF_FFFC, transfer, PC wraps to 0
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_006F;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        #1;
        chk("wrap_valid", {31'b0, if_valid}, 32'd1);
        chk("wrap_inst",  if_inst, 32'h0000_006F);
        chk("wrap_pc",    if_pc, 32'hFFFF_FFFC);
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        #1;
        chk("wrap_req",  {31'b0, imem_req}, 32'd1);
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset in the middle of a fetch clears everything immediately
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_req",   {31'b0, imem_req}, 32'd0);
        chk("mrst_addr",  imem_addr, 32'h0);
        chk("mrst_valid", {31'b0, if_valid}, 32'd0);
        chk("mrst_pc",    if_pc, 32'h0);
        chk("mrst_inst",  if_inst, 32'h0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("mrst_req1", {31'b0, imem_req}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
